// File: rtl/mac_seq_pkg.sv
// Shared types and default widths for the MAC sequencer and its pacer.
package mac_seq_pkg;

   localparam int unsigned DEF_OP_W  = 8;
   localparam int unsigned DEF_RES_W = 20;

   typedef enum logic [3:0] {
      IDLE,
      START,
      GAP_S,
      ACCEPT,
      LOAD,
      NEXT,
      WAIT_MUL,
      GAP_M,
      WAIT_FIN,
      GAP_F,
      UNLOAD,
      RESULT
   } mac_seq_state_t;

endpackage

// File: rtl/mac_bit_pacer.sv
// Generates the paced shift strobe for a burst of nbits bit periods.
// bit_tick and done mark the last cycle of each period and of the whole burst.
module mac_bit_pacer #(
   parameter int unsigned SHIFT_HI = 2,
   parameter int unsigned SHIFT_LO = 2,
   parameter int unsigned NB_W     = 5
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            go,
   input  logic [NB_W-1:0] nbits,
   output logic            strobe,
   output logic            bit_tick,
   output logic            done
);

   localparam int unsigned PER  = SHIFT_HI + SHIFT_LO;
   localparam int unsigned PH_W = $clog2(PER + 1);

   logic            active, active_nx;
   logic [PH_W-1:0] phase, phase_nx;
   logic [NB_W-1:0] bit_cnt, bit_nx;
   logic [NB_W-1:0] nb, nb_nx;

   // Next position within the burst; outputs are registered from it.
   always_comb begin
      active_nx = active;
      phase_nx  = phase;
      bit_nx    = bit_cnt;
      nb_nx     = nb;
      if (go) begin
         active_nx = 1'b1;
         phase_nx  = '0;
         bit_nx    = '0;
         nb_nx     = nbits;
      end else if (active) begin
         if (bit_tick) begin
            phase_nx = '0;
            bit_nx   = bit_cnt + NB_W'(1);
            if (done) active_nx = 1'b0;
         end else begin
            phase_nx = phase + PH_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         active   <= 1'b0;
         phase    <= '0;
         bit_cnt  <= '0;
         nb       <= '0;
         strobe   <= 1'b0;
         bit_tick <= 1'b0;
         done     <= 1'b0;
      end else begin
         active   <= active_nx;
         phase    <= phase_nx;
         bit_cnt  <= bit_nx;
         nb       <= nb_nx;
         strobe   <= active_nx && (32'(phase_nx) < SHIFT_HI);
         bit_tick <= active_nx && (32'(phase_nx) == PER - 1);
         done     <= active_nx && (32'(phase_nx) == PER - 1) && (bit_nx == nb_nx - NB_W'(1));
      end
   end

endmodule

// File: rtl/mac_sequencer.sv
// Feeds operand pairs serially into the MAC core, then unloads the accumulator
// and presents it on a valid/ready result port.
module mac_sequencer
   import mac_seq_pkg::*;
#(
   parameter int unsigned OP_W     = DEF_OP_W,
   parameter int unsigned RES_W    = DEF_RES_W,
   parameter int unsigned SHIFT_HI = 2,
   parameter int unsigned SHIFT_LO = 2,
   parameter int unsigned GAP      = 4,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_start,
   input  logic [3:0]       num_terms,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [OP_W-1:0]  op_a,
   input  logic [OP_W-1:0]  op_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [RES_W-1:0] result,
   output logic             res_carry,
   output logic             busy,
   output logic             error,
   output logic             mac_start,
   output logic             mac_shift_a,
   output logic             mac_shift_b,
   output logic             mac_shift,
   output logic             mac_do_next,
   input  logic             mac_end_mul,
   input  logic             mac_finish,
   input  logic             mac_shiftout,
   input  logic             mac_carry_out
);

   localparam int unsigned NB_W  = $clog2(((OP_W > RES_W) ? OP_W : RES_W) + 1);
   localparam int unsigned GAP_W = $clog2(GAP + 1);
   localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

   mac_seq_state_t   state;
   logic [3:0]       terms, term_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic [TO_W-1:0]  to_cnt;
   logic [OP_W-2:0]  sh_a, sh_b;
   logic [RES_W-1:0] sh_res;
   logic             shift_q;
   logic             accept, gap_last, pace_go, bit_tick, pace_done;
   logic [NB_W-1:0]  pace_nbits;

   assign accept     = (state == ACCEPT) && op_valid && op_ready;
   assign gap_last   = (32'(gap_cnt) == GAP - 1);
   assign pace_go    = accept || ((state == GAP_F) && gap_last);
   assign pace_nbits = (state == GAP_F) ? NB_W'(RES_W) : NB_W'(OP_W);

   mac_bit_pacer #(
      .SHIFT_HI (SHIFT_HI),
      .SHIFT_LO (SHIFT_LO),
      .NB_W     (NB_W)
   ) u_pacer (
      .clock    (clock),
      .reset    (reset),
      .go       (pace_go),
      .nbits    (pace_nbits),
      .strobe   (mac_shift),
      .bit_tick (bit_tick),
      .done     (pace_done)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= IDLE;
         terms       <= '0;
         term_cnt    <= '0;
         gap_cnt     <= '0;
         to_cnt      <= '0;
         sh_a        <= '0;
         sh_b        <= '0;
         sh_res      <= '0;
         shift_q     <= 1'b0;
         op_ready    <= 1'b0;
         res_valid   <= 1'b0;
         result      <= '0;
         res_carry   <= 1'b0;
         busy        <= 1'b0;
         error       <= 1'b0;
         mac_start   <= 1'b0;
         mac_shift_a <= 1'b0;
         mac_shift_b <= 1'b0;
         mac_do_next <= 1'b0;
      end else begin
         mac_start   <= 1'b0;
         mac_do_next <= 1'b0;
         shift_q     <= mac_shift;
         case (state)
            IDLE: if (cmd_start) begin
               state     <= START;
               mac_start <= 1'b1;
               busy      <= 1'b1;
               error     <= 1'b0;
               term_cnt  <= '0;
               terms     <= (num_terms == 4'd0) ? 4'd1 : num_terms;
            end
            START: begin
               state   <= GAP_S;
               gap_cnt <= '0;
            end
            GAP_S: if (gap_last) begin
               state    <= ACCEPT;
               op_ready <= 1'b1;
            end else begin
               gap_cnt <= gap_cnt + GAP_W'(1);
            end
            ACCEPT: if (accept) begin
               state       <= LOAD;
               op_ready    <= 1'b0;
               mac_shift_a <= op_a[OP_W-1];
               mac_shift_b <= op_b[OP_W-1];
               sh_a        <= op_a[OP_W-2:0];
               sh_b        <= op_b[OP_W-2:0];
            end
            // Operand bits change only at the end of a full bit period.
            LOAD: if (bit_tick) begin
               if (pace_done) begin
                  state       <= NEXT;
                  mac_do_next <= 1'b1;
                  mac_shift_a <= 1'b0;
                  mac_shift_b <= 1'b0;
               end else begin
                  mac_shift_a <= sh_a[OP_W-2];
                  mac_shift_b <= sh_b[OP_W-2];
                  sh_a        <= {sh_a[OP_W-3:0], 1'b0};
                  sh_b        <= {sh_b[OP_W-3:0], 1'b0};
               end
            end
            NEXT: begin
               state    <= WAIT_MUL;
               term_cnt <= term_cnt + 4'd1;
               to_cnt   <= '0;
            end
            WAIT_MUL: if (mac_end_mul) begin
               state   <= GAP_M;
               gap_cnt <= '0;
            end else if (32'(to_cnt) == TIMEOUT) begin
               state <= IDLE;
               error <= 1'b1;
               busy  <= 1'b0;
            end else begin
               to_cnt <= to_cnt + TO_W'(1);
            end
            GAP_M: if (gap_last) begin
               if (term_cnt < terms) begin
                  state    <= ACCEPT;
                  op_ready <= 1'b1;
               end else begin
                  state  <= WAIT_FIN;
                  to_cnt <= '0;
               end
            end else begin
               gap_cnt <= gap_cnt + GAP_W'(1);
            end
            WAIT_FIN: if (mac_finish) begin
               state   <= GAP_F;
               gap_cnt <= '0;
            end else if (32'(to_cnt) == TIMEOUT) begin
               state <= IDLE;
               error <= 1'b1;
               busy  <= 1'b0;
            end else begin
               to_cnt <= to_cnt + TO_W'(1);
            end
            GAP_F: if (gap_last) begin
               state     <= UNLOAD;
               res_carry <= mac_carry_out;
               sh_res    <= '0;
            end else begin
               gap_cnt <= gap_cnt + GAP_W'(1);
            end
            // Accumulator arrives LSB first, one bit per rising strobe.
            UNLOAD: begin
               if (mac_shift && !shift_q) sh_res <= {mac_shiftout, sh_res[RES_W-1:1]};
               if (pace_done) begin
                  state     <= RESULT;
                  res_valid <= 1'b1;
                  result    <= sh_res;
               end
            end
            RESULT: if (res_ready) begin
               state     <= IDLE;
               res_valid <= 1'b0;
               busy      <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
